// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared defaults and helpers for the multi-port register file
package regfile_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  function automatic logic is_zero_reg(input logic [31:0] addr, input bit zero_reg);
    return zero_reg && addr == 32'd0;
  endfunction
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: decoder/WB bus of the register file (master = pipeline, slave = regfile)
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
);
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     issue_en;
  logic [ADDR_W-1:0]        issue_addr;
  modport master(output wr_en, wr_addr, wr_data, rd_addr, issue_en, issue_addr, input rd_data, rd_busy);
  modport slave(input wr_en, wr_addr, wr_data, rd_addr, issue_en, issue_addr, output rd_data, rd_busy);
endinterface

// File: rtl/regfile_mp_fwd_mux.sv
// regfile_fwd_mux: per-read-port zero/bypass/storage select plus bypass-hit flag
module regfile_fwd_mux
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic [ADDR_W-1:0]        rd_addr,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0]        reg_data,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     hit
);
  logic [DATA_W-1:0] fwd;
  always_comb begin
    hit = 1'b0;
    fwd = '0;
    for (int i = 0; i < NUM_WR; i++)
      if (BYPASS != 0 && wr_en[i] && wr_addr[i*ADDR_W +: ADDR_W] == rd_addr) begin
        hit = 1'b1;
        fwd = wr_data[i*DATA_W +: DATA_W];
      end
    rd_data = is_zero_reg(32'(rd_addr), ZERO_REG != 0) ? '0 : hit ? fwd : reg_data;
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with bypass and pending scoreboard
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic      clk,
  input logic      rst,
  regfile_mp_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pending;
  // Ascending loop: the last non-blocking assignment wins, so the highest port has priority.
  // The issue update follows the writes so a new producer overrides a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs    <= '{default: '0};
      pending <= '0;
    end else begin
      for (int i = 0; i < NUM_WR; i++)
        if (bus.wr_en[i]) begin
          if (!is_zero_reg(32'(bus.wr_addr[i*ADDR_W +: ADDR_W]), ZERO_REG != 0))
            regs[bus.wr_addr[i*ADDR_W +: ADDR_W]] <= bus.wr_data[i*DATA_W +: DATA_W];
          pending[bus.wr_addr[i*ADDR_W +: ADDR_W]] <= 1'b0;
        end
      if (bus.issue_en && !is_zero_reg(32'(bus.issue_addr), ZERO_REG != 0))
        pending[bus.issue_addr] <= 1'b1;
    end
  end
  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              hit;
    assign addr = bus.rd_addr[j*ADDR_W +: ADDR_W];
    regfile_fwd_mux #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_WR(NUM_WR), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_mux (
      .rd_addr(addr), .wr_en(bus.wr_en), .wr_addr(bus.wr_addr), .wr_data(bus.wr_data),
      .reg_data(regs[addr]), .rd_data(data), .hit(hit)
    );
    // Outputs are forced low during reset so bypassed write data cannot leak out.
    assign bus.rd_data[j*DATA_W +: DATA_W] = rst ? '0 : data;
    assign bus.rd_busy[j] = !rst && pending[addr] && !hit;
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of regfile_mp (bypass, no-bypass and wide/narrow builds)
module tb_regfile_mp;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int passed = 0;
  int total = 0;
  always #5 clk = ~clk;
  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) a ();
  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) b ();
  regfile_mp_if #(.DATA_W(64), .ADDR_W(3), .NUM_RD(4), .NUM_WR(1)) c ();
  assign b.wr_en = a.wr_en;
  assign b.wr_addr = a.wr_addr;
  assign b.wr_data = a.wr_data;
  assign b.rd_addr = a.rd_addr;
  assign b.issue_en = a.issue_en;
  assign b.issue_addr = a.issue_addr;
  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1))
    u_a (.clk(clk), .rst(rst), .bus(a));
  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(0))
    u_b (.clk(clk), .rst(rst), .bus(b));
  regfile_mp #(.DATA_W(64), .ADDR_W(3), .NUM_RD(4), .NUM_WR(1), .ZERO_REG(1), .BYPASS(1))
    u_c (.clk(clk), .rst(rst), .bus(c));

  task automatic clr();
    a.wr_en = '0;
    a.issue_en = 1'b0;
  endtask

  task automatic test_reset();
    a.wr_en = '0; a.wr_addr = '0; a.wr_data = '0; a.rd_addr = {5'd6, 5'd5};
    a.issue_en = 1'b0; a.issue_addr = '0;
    c.wr_en = '0; c.wr_addr = '0; c.wr_data = '0; c.rd_addr = '0;
    c.issue_en = 1'b0; c.issue_addr = '0;
    #3;
    total++; if (a.rd_data !== 64'd0) $display("FAIL reset_rd_data got %h want 0", a.rd_data); else passed++;
    total++; if (a.rd_busy !== 2'b00) $display("FAIL reset_rd_busy got %b want 00", a.rd_busy); else passed++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    a.wr_en = 2'b01; a.wr_addr = {5'd0, 5'd5}; a.wr_data = {32'd0, 32'hDEADBEEF};
    a.issue_en = 1'b1; a.issue_addr = 5'd6;
    @(posedge clk); #1;
    clr();
    #1;
    total++; if (a.rd_data[31:0] !== 32'hDEADBEEF) $display("FAIL pre_rst_r5 got %h want deadbeef", a.rd_data[31:0]); else passed++;
    total++; if (a.rd_busy[1] !== 1'b1) $display("FAIL pre_rst_busy_r6 got %b want 1", a.rd_busy[1]); else passed++;
    #1 rst = 1'b1;
    #1;
    total++; if (a.rd_data[31:0] !== 32'd0) $display("FAIL async_rst_r5 got %h want 0", a.rd_data[31:0]); else passed++;
    total++; if (a.rd_busy !== 2'b00) $display("FAIL async_rst_busy got %b want 00", a.rd_busy); else passed++;
    #1 rst = 1'b0;
    @(negedge clk); #1;
    total++; if (a.rd_data[31:0] !== 32'd0) $display("FAIL post_rst_r5 got %h want 0", a.rd_data[31:0]); else passed++;
    total++; if (a.rd_busy[1] !== 1'b0) $display("FAIL post_rst_busy_r6 got %b want 0", a.rd_busy[1]); else passed++;
  endtask

  task automatic test_collision();
    @(negedge clk);
    a.wr_en = 2'b11; a.wr_addr = {5'd7, 5'd7}; a.wr_data = {32'h22, 32'h11}; a.rd_addr = {5'd7, 5'd7};
    #1;
    total++; if (a.rd_data !== {32'h22, 32'h22}) $display("FAIL coll_bypass got %h want 22 on both", a.rd_data); else passed++;
    total++; if (b.rd_data[31:0] !== 32'd0) $display("FAIL coll_nobyp_old got %h want 0", b.rd_data[31:0]); else passed++;
    @(posedge clk); #1;
    clr();
    #1;
    total++; if (a.rd_data[31:0] !== 32'h22) $display("FAIL coll_stored got %h want 22", a.rd_data[31:0]); else passed++;
    total++; if (b.rd_data[63:32] !== 32'h22) $display("FAIL coll_nobyp_stored got %h want 22", b.rd_data[63:32]); else passed++;
  endtask

  task automatic test_zero();
    @(negedge clk);
    a.wr_en = 2'b10; a.wr_addr = {5'd0, 5'd0}; a.wr_data = {32'h1234, 32'h0};
    a.issue_en = 1'b1; a.issue_addr = 5'd0; a.rd_addr = {5'd7, 5'd0};
    #1;
    total++; if (a.rd_data[31:0] !== 32'd0) $display("FAIL zero_bypass got %h want 0", a.rd_data[31:0]); else passed++;
    @(posedge clk); #1;
    clr();
    #1;
    total++; if (a.rd_data[31:0] !== 32'd0) $display("FAIL zero_stored got %h want 0", a.rd_data[31:0]); else passed++;
    total++; if (a.rd_busy[0] !== 1'b0) $display("FAIL zero_busy got %b want 0", a.rd_busy[0]); else passed++;
  endtask

  task automatic test_bypass();
    @(negedge clk);
    a.wr_en = 2'b01; a.wr_addr = {5'd0, 5'd3}; a.wr_data = {32'd0, 32'hA5A5}; a.rd_addr = {5'd7, 5'd3};
    #1;
    total++; if (a.rd_data[31:0] !== 32'hA5A5) $display("FAIL byp_same_cycle got %h want a5a5", a.rd_data[31:0]); else passed++;
    total++; if (b.rd_data[31:0] !== 32'd0) $display("FAIL nobyp_same_cycle got %h want 0", b.rd_data[31:0]); else passed++;
    total++; if (b.rd_data[63:32] !== 32'h22) $display("FAIL nobyp_other_port got %h want 22", b.rd_data[63:32]); else passed++;
    @(posedge clk); #1;
    clr();
    #1;
    total++; if (b.rd_data[31:0] !== 32'hA5A5) $display("FAIL nobyp_next_cycle got %h want a5a5", b.rd_data[31:0]); else passed++;
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    a.issue_en = 1'b1; a.issue_addr = 5'd9; a.rd_addr = {5'd3, 5'd9};
    #1;
    total++; if (a.rd_busy[0] !== 1'b0) $display("FAIL sb_before_edge got %b want 0", a.rd_busy[0]); else passed++;
    @(posedge clk); #1;
    clr();
    #1;
    total++; if (a.rd_busy !== 2'b01) $display("FAIL sb_issued got %b want 01", a.rd_busy); else passed++;
    total++; if (b.rd_busy[0] !== 1'b1) $display("FAIL sb_issued_nobyp got %b want 1", b.rd_busy[0]); else passed++;
    @(negedge clk);
    a.wr_en = 2'b10; a.wr_addr = {5'd9, 5'd0}; a.wr_data = {32'h99, 32'd0};
    #1;
    total++; if (a.rd_busy[0] !== 1'b0) $display("FAIL sb_write_byp got %b want 0", a.rd_busy[0]); else passed++;
    total++; if (b.rd_busy[0] !== 1'b1) $display("FAIL sb_write_nobyp got %b want 1", b.rd_busy[0]); else passed++;
    @(posedge clk); #1;
    clr();
    #1;
    total++; if (b.rd_busy[0] !== 1'b0) $display("FAIL sb_cleared_nobyp got %b want 0", b.rd_busy[0]); else passed++;
    total++; if (a.rd_data[31:0] !== 32'h99) $display("FAIL sb_r9_data got %h want 99", a.rd_data[31:0]); else passed++;
    @(negedge clk);
    a.wr_en = 2'b01; a.wr_addr = {5'd0, 5'd9}; a.wr_data = {32'd0, 32'h77};
    a.issue_en = 1'b1; a.issue_addr = 5'd9;
    @(posedge clk); #1;
    clr();
    #1;
    total++; if (a.rd_busy[0] !== 1'b1) $display("FAIL sb_set_wins got %b want 1", a.rd_busy[0]); else passed++;
    total++; if (b.rd_busy[0] !== 1'b1) $display("FAIL sb_set_wins_nobyp got %b want 1", b.rd_busy[0]); else passed++;
    total++; if (a.rd_data[31:0] !== 32'h77) $display("FAIL sb_r9_new_data got %h want 77", a.rd_data[31:0]); else passed++;
  endtask

  task automatic test_sweep();
    logic [63:0] m [8];
    logic [63:0] exp;
    logic [2:0] ra;
    for (int k = 0; k < 8; k++) m[k] = '0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      c.wr_en = 1'($urandom_range(0, 1));
      c.wr_addr = 3'($urandom_range(0, 7));
      c.wr_data = {$urandom, $urandom};
      c.rd_addr = 12'($urandom);
      if (n % 5 == 0) c.rd_addr[2:0] = c.wr_addr;
      #1;
      for (int j = 0; j < 4; j++) begin
        ra = c.rd_addr[j*3 +: 3];
        exp = (ra == 3'd0) ? 64'd0 : (c.wr_en[0] && c.wr_addr == ra) ? c.wr_data : m[ra];
        total++;
        if (c.rd_data[j*64 +: 64] !== exp) $display("FAIL sweep_rd%0d_iter%0d got %h want %h", j, n, c.rd_data[j*64 +: 64], exp);
        else passed++;
      end
      @(posedge clk);
      if (c.wr_en[0] && c.wr_addr != 3'd0) m[c.wr_addr] = c.wr_data;
    end
    @(negedge clk);
    c.wr_en = '0;
  endtask

  initial begin
    test_reset();
    test_collision();
    test_zero();
    test_bypass();
    test_scoreboard();
    test_sweep();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
